sd_wb_slave: RTL
================

# sd_wb_slave

Wishbone slave front-end of the SD host controller; sits directly downstream of the testbench/system Wishbone master. Decodes the 5-bit address map (0-15 registers, 16 command exec, 17 TX FIFO write, 18 RX FIFO read, 19 data exec) and drives the command and data engines. Returns a single-cycle `ack_o`, or `error_o` on an illegal or failed access. Buffers 128-bit payload words in a TX FIFO and an RX FIFO.

## Interface
- `FIFO_DEPTH`, 8, entries per FIFO (power of two, ≥2)
- `EXEC_TIMEOUT`, 1024, max cycles waited for cmd/data done
- `wb_clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `strobe_i`  in  1  access request, held by master until ack/error seen
- `we_i`  in  1  1 = write, 0 = read
- `adr_i`  in  5  address
- `wb_data_i`  in  128  write data
- `ack_o`  out  1  access complete, one-cycle pulse
- `error_o`  out  1  access failed, one-cycle pulse
- `wb_data_o`  out  128  read data, valid with `ack_o`
- `cfg_o`  out  128  {reg3, reg2, reg1, reg0}
- `cmd_start_o`  out  1  one-cycle command start pulse
- `cmd_done_i`  in  1  command engine finished
- `data_start_o`  out  1  one-cycle data start pulse
- `data_done_i`  in  1  data engine finished
- `tx_pop_i`  in  1  data engine pops TX head
- `tx_data_o`  out  128  TX FIFO head (show-ahead)
- `tx_empty_o`  out  1  TX FIFO empty
- `rx_push_i`  in  1  data engine pushes `rx_data_i`
- `rx_data_i`  in  128  RX write data
- `rx_full_o`  out  1  RX FIFO full

## Operation
- States: IDLE, CMD_WAIT, DATA_WAIT, RELEASE.
- IDLE, `strobe_i`=1 sampled at edge k: access is decoded at that edge.
- Register write, adr 0-14: reg[adr] <= `wb_data_i[31:0]`. Then ack, go to RELEASE.
- Register read, adr 0-14: `wb_data_o` <= {96'b0, reg[adr]}. Then ack, go to RELEASE.
- Adr 15: read-only status {96'b0, 16'b0, tx_count[7:0], rx_count[7:0]}, counts zero-extended. A write to 15 is ignored and acked.
- Adr 17 write: push `wb_data_i` into TX, then ack. If TX is full: no push, error_o.
- Adr 18 read: pop RX head into `wb_data_o`, then ack. If RX is empty: `wb_data_o` unchanged, error_o.
- Adr 16 or 19, either `we_i`:
  - assert `cmd_start_o` / `data_start_o` for one cycle;
  - go to CMD_WAIT / DATA_WAIT and clear the timeout counter.
- In CMD_WAIT / DATA_WAIT:
  - the matching done input sampled high gives ack_o and goes to RELEASE;
  - the counter reaching `EXEC_TIMEOUT` gives error_o and goes to RELEASE;
  - done and timeout on the same edge: done wins.
- Adr 17 read, adr 18 write, adr 20-31: error_o, no side effects.
- RELEASE: wait for `strobe_i`=0, then IDLE. This prevents double-servicing a held strobe.
- `cmd_done_i` / `data_done_i` seen outside the matching WAIT state are ignored.
- Data-engine FIFO sides operate in any state:
  - `tx_pop_i` when TX is empty is ignored;
  - `rx_push_i` when RX is full is dropped.
- Simultaneous push and pop on one FIFO (not empty) both take effect; count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - `ack_o`, `error_o`, `cmd_start_o`, `data_start_o` = 0;
  - `wb_data_o`, `cfg_o`, reg0-14 = 0;
  - FIFOs empty (`tx_empty_o`=1, `rx_full_o`=0, `tx_data_o`=0);
  - state IDLE, timeout counter 0.
- Reset mid-wait aborts the access. No ack or error is issued.
- All outputs are registered.
- Register/FIFO access: strobe sampled at edge k; `ack_o` or `error_o` high from edge k to edge k+1. `wb_data_o` updates at edge k.
- Exec: `*_start_o` high from edge k to k+1. Done sampled at edge m gives `ack_o` high from m to m+1. Minimum ack latency is 1 cycle after the start pulse.
- `ack_o` and `error_o` are never high together. There is at most one response per strobe assertion.
- `cfg_o` reflects a register write from edge k.
- FIFO flags update on the edge of the push or pop.

## Test plan
- Write 0xDEADBEEF to adr 3, then read adr 3: one ack per access, `wb_data_o`=0x...DEADBEEF, `cfg_o[127:96]`=0xDEADBEEF.
- Write 8 words (4, 9, 14, …) to adr 17:
  - 8 acks; status reads tx_count=8;
  - 9th write gives error_o, count stays 8;
  - 8 `tx_pop_i` pulses yield the same words in order, then `tx_empty_o`=1.
- Read adr 18 when empty: error_o. Then `rx_push_i` 3 words and read adr 18 three times: three acks, data in order.
- Write adr 16 with `cmd_done_i` raised 5 cycles after `cmd_start_o`: ack exactly 1 cycle after the done edge. Holding strobe for 10 more cycles gives no second start.
- Write adr 19 with no `data_done_i`: error_o after `EXEC_TIMEOUT`=1024 cycles. With reset asserted at cycle 500 instead: no response, all outputs at reset values.
- Access adr 20 and adr 31: error_o, no state change. Simultaneous `rx_push_i` + adr 18 pop with RX holding 2 entries: count stays 2.

Source files
------------

// File: rtl/sd_wb_slave.sv
// Wishbone slave front-end of the SD host controller: register file, exec
// handshakes toward the command/data engines, and TX/RX 128-bit payload FIFOs.
module sd_wb_slave #(
  parameter int FIFO_DEPTH   = 8,
  parameter int EXEC_TIMEOUT = 1024
) (
  input  logic         wb_clock,
  input  logic         reset,
  input  logic         strobe_i,
  input  logic         we_i,
  input  logic [4:0]   adr_i,
  input  logic [127:0] wb_data_i,
  output logic         ack_o,
  output logic         error_o,
  output logic [127:0] wb_data_o,
  output logic [127:0] cfg_o,
  output logic         cmd_start_o,
  input  logic         cmd_done_i,
  output logic         data_start_o,
  input  logic         data_done_i,
  input  logic         tx_pop_i,
  output logic [127:0] tx_data_o,
  output logic         tx_empty_o,
  input  logic         rx_push_i,
  input  logic [127:0] rx_data_i,
  output logic         rx_full_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(EXEC_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CMD_WAIT, DATA_WAIT, RELEASE} state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           ack_q, ack_d;
  logic           error_q, error_d;
  logic           cmd_start_q, cmd_start_d;
  logic           data_start_q, data_start_d;
  logic [127:0]   rdata_q, rdata_d;
  logic [31:0]    regs_q [15];
  logic [31:0]    regs_d [15];

  logic [127:0]   tx_mem_q [FIFO_DEPTH];
  logic [127:0]   tx_mem_d [FIFO_DEPTH];
  logic [PW-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [127:0]   rx_mem_q [FIFO_DEPTH];
  logic [127:0]   rx_mem_d [FIFO_DEPTH];
  logic [PW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;

  logic tx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] tx_cnt8, rx_cnt8;

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_cnt8  = 8'(tx_cnt_q);
  assign rx_cnt8  = 8'(rx_cnt_q);

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    ack_d        = 1'b0;
    error_d      = 1'b0;
    cmd_start_d  = 1'b0;
    data_start_d = 1'b0;
    rdata_d      = rdata_q;
    regs_d       = regs_q;
    tx_push      = 1'b0;
    rx_pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (strobe_i) begin
          state_d = RELEASE;
          if (adr_i < 5'd15) begin
            ack_d = 1'b1;
            if (we_i) regs_d[adr_i[3:0]] = wb_data_i[31:0];
            else      rdata_d = {96'b0, regs_q[adr_i[3:0]]};
          end else begin
            case (adr_i)
              5'd15: begin
                ack_d = 1'b1;
                if (!we_i) rdata_d = {112'b0, tx_cnt8, rx_cnt8};
              end
              5'd16: begin
                cmd_start_d = 1'b1;
                state_d     = CMD_WAIT;
                tmo_cnt_d   = '0;
              end
              5'd19: begin
                data_start_d = 1'b1;
                state_d      = DATA_WAIT;
                tmo_cnt_d    = '0;
              end
              5'd17: begin
                if (we_i && !tx_full) begin
                  ack_d   = 1'b1;
                  tx_push = 1'b1;
                end else begin
                  error_d = 1'b1;
                end
              end
              5'd18: begin
                if (!we_i && !rx_empty) begin
                  ack_d   = 1'b1;
                  rx_pop  = 1'b1;
                  rdata_d = rx_mem_q[rx_rd_q];
                end else begin
                  error_d = 1'b1;
                end
              end
              default: error_d = 1'b1;
            endcase
          end
        end
      end
      CMD_WAIT, DATA_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // done takes priority over a timeout landing on the same edge
        if ((state_q == CMD_WAIT) ? cmd_done_i : data_done_i) begin
          ack_d   = 1'b1;
          state_d = RELEASE;
        end else if (tmo_cnt_q == TW'(EXEC_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!strobe_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tx_pop   = tx_pop_i && (tx_cnt_q != '0);
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = wb_data_i;
      tx_wr_d           = tx_wr_q + 1'b1;
    end
    if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;

    rx_push  = rx_push_i && (rx_cnt_q != CW'(FIFO_DEPTH));
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = rx_data_i;
      rx_wr_d           = rx_wr_q + 1'b1;
    end
    if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
  end

  always_ff @(posedge wb_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tmo_cnt_q    <= '0;
      ack_q        <= 1'b0;
      error_q      <= 1'b0;
      cmd_start_q  <= 1'b0;
      data_start_q <= 1'b0;
      rdata_q      <= '0;
      regs_q       <= '{default: '0};
      tx_mem_q     <= '{default: '0};
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      tx_cnt_q     <= '0;
      rx_mem_q     <= '{default: '0};
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ack_q        <= ack_d;
      error_q      <= error_d;
      cmd_start_q  <= cmd_start_d;
      data_start_q <= data_start_d;
      rdata_q      <= rdata_d;
      regs_q       <= regs_d;
      tx_mem_q     <= tx_mem_d;
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_mem_q     <= rx_mem_d;
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      rx_cnt_q     <= rx_cnt_d;
    end
  end

  assign ack_o        = ack_q;
  assign error_o      = error_q;
  assign cmd_start_o  = cmd_start_q;
  assign data_start_o = data_start_q;
  assign wb_data_o    = rdata_q;
  assign cfg_o        = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign tx_data_o    = tx_mem_q[tx_rd_q];
  assign tx_empty_o   = (tx_cnt_q == '0);
  assign rx_full_o    = (rx_cnt_q == CW'(FIFO_DEPTH));

endmodule
